// File: rtl/pipe_stage_chain_if.sv
// rtl/pipe_stage_chain_if.sv - upstream/downstream bundle of the pipeline stage chain
interface pipe_stage_chain_if #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data1;
    logic [DATA_W-1:0] in_data2;
    logic [FUNC_W-1:0] in_func;
    logic              in_ready;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_data1;
    logic [DATA_W-1:0] out_data2;
    logic [FUNC_W-1:0] out_func;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, in_data1, in_data2, in_func, stall, flush,
        input  in_ready, out_valid, out_data1, out_data2, out_func, stall_cnt
    );

    modport slave (
        input  in_valid, in_data1, in_data2, in_func, stall, flush,
        output in_ready, out_valid, out_data1, out_data2, out_func, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - N-stage pipeline register chain with stall, flush, bubbles and stall counter
module pipe_stage_chain #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    pipe_stage_chain_if.slave  io_bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0] w_hold;
    logic [CNT_W-1:0]  r_cnt;

    // A stall anywhere downstream freezes every stage upstream of it.
    always_comb begin
        w_hold = '0;
        for (int j = 0; j < STAGES; j++) begin
            w_hold[j] = |(io_bus.stall >> j);
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic              r_valid;
        logic [DATA_W-1:0] r_d1;
        logic [DATA_W-1:0] r_d2;
        logic [FUNC_W-1:0] r_f;
        logic              w_bubble;
        logic              w_src_v;
        logic [DATA_W-1:0] w_src_d1;
        logic [DATA_W-1:0] w_src_d2;
        logic [FUNC_W-1:0] w_src_f;

        if (g == 0) begin : g_head
            assign w_bubble = 1'b0;
            assign w_src_v  = io_bus.in_valid;
            assign w_src_d1 = io_bus.in_valid ? io_bus.in_data1 : '0;
            assign w_src_d2 = io_bus.in_valid ? io_bus.in_data2 : '0;
            assign w_src_f  = io_bus.in_valid ? io_bus.in_func  : '0;
        end else begin : g_body
            assign w_bubble = w_hold[g-1];
            assign w_src_v  = g_stage[g-1].r_valid;
            assign w_src_d1 = g_stage[g-1].r_d1;
            assign w_src_d2 = g_stage[g-1].r_d2;
            assign w_src_f  = g_stage[g-1].r_f;
        end

        // Priority: flush, then hold, then bubble (upstream frozen), then load.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_d1    <= '0;
                r_d2    <= '0;
                r_f     <= '0;
            end else if (io_bus.flush[g]) begin
                r_valid <= 1'b0;
                r_d1    <= '0;
                r_d2    <= '0;
                r_f     <= '0;
            end else if (!w_hold[g]) begin
                if (w_bubble) begin
                    r_valid <= 1'b0;
                    r_d1    <= '0;
                    r_d2    <= '0;
                    r_f     <= '0;
                end else begin
                    r_valid <= w_src_v;
                    r_d1    <= w_src_d1;
                    r_d2    <= w_src_d2;
                    r_f     <= w_src_f;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_hold[0] && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign io_bus.in_ready  = ~w_hold[0];
    assign io_bus.out_valid = g_stage[STAGES-1].r_valid;
    assign io_bus.out_data1 = g_stage[STAGES-1].r_d1;
    assign io_bus.out_data2 = g_stage[STAGES-1].r_d2;
    assign io_bus.out_func  = g_stage[STAGES-1].r_f;
    assign io_bus.stall_cnt = r_cnt;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - bench for pipe_stage_chain with a reference model
module tb_pipe_stage_chain;
    localparam int NS = 2;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pipe_stage_chain_if #(.DATA_W(32), .FUNC_W(4), .STAGES(NS), .CNT_W(16)) bus ();
    pipe_stage_chain_if #(.DATA_W(32), .FUNC_W(4), .STAGES(1),  .CNT_W(4))  sif ();

    pipe_stage_chain #(.DATA_W(32), .FUNC_W(4), .STAGES(NS), .CNT_W(16)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    pipe_stage_chain #(.DATA_W(32), .FUNC_W(4), .STAGES(1), .CNT_W(4)) u_sat (
        .clk    (clk),
        .reset  (reset),
        .io_bus (sif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        m_v  [NS];
    logic [31:0] m_d1 [NS];
    logic [31:0] m_d2 [NS];
    logic [3:0]  m_f  [NS];
    int unsigned m_cnt;

    function automatic bit held(int j, logic [NS-1:0] st);
        for (int k = j; k < NS; k++) if (st[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int j = 0; j < NS; j++) begin
            m_v[j] = 1'b0; m_d1[j] = '0; m_d2[j] = '0; m_f[j] = '0;
        end
        m_cnt = 0;
    endtask

    // Walk from the output side so each stage reads its predecessor's old value.
    task automatic model_edge();
        for (int j = NS - 1; j >= 0; j--) begin
            if (bus.flush[j] || (!held(j, bus.stall) && j > 0 && held(j - 1, bus.stall))) begin
                m_v[j] = 1'b0; m_d1[j] = '0; m_d2[j] = '0; m_f[j] = '0;
            end else if (!held(j, bus.stall)) begin
                if (j == 0) begin
                    m_v[0]  = bus.in_valid;
                    m_d1[0] = bus.in_valid ? bus.in_data1 : 32'h0;
                    m_d2[0] = bus.in_valid ? bus.in_data2 : 32'h0;
                    m_f[0]  = bus.in_valid ? bus.in_func  : 4'h0;
                end else begin
                    m_v[j] = m_v[j-1]; m_d1[j] = m_d1[j-1]; m_d2[j] = m_d2[j-1]; m_f[j] = m_f[j-1];
                end
            end
        end
        if (held(0, bus.stall) && m_cnt < 65535) m_cnt++;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        chk("out_valid", bus.out_valid, m_v[NS-1]);
        chk("out_data1", bus.out_data1, m_d1[NS-1]);
        chk("out_data2", bus.out_data2, m_d2[NS-1]);
        chk("out_func",  bus.out_func,  m_f[NS-1]);
        chk("stall_cnt", bus.stall_cnt, m_cnt);
    endtask

    task automatic cycle();
        #1;
        chk("in_ready", bus.in_ready, !held(0, bus.stall));
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_clear();
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_cnt", bus.stall_cnt, 16'h0);
        chk("rst_sat_cnt", sif.stall_cnt, 4'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data1 = '0; bus.in_data2 = '0; bus.in_func = '0;
        bus.stall = '0; bus.flush = '0;
        sif.in_valid = 1'b0; sif.in_data1 = '0; sif.in_data2 = '0; sif.in_func = '0;
        sif.stall = '0; sif.flush = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted mid-stream clears outputs without a clock edge.
        bus.in_valid = 1'b1; bus.in_data1 = 32'hDEADBEEF; bus.in_data2 = 32'h1234; bus.in_func = 4'h7;
        cycle();
        cycle();
        chk("pre_rst_d1", bus.out_data1, 32'hDEADBEEF);
        cycle();
        #2 reset = 1'b1;
        #1;
        chk("rst_async_valid", bus.out_valid, 1'b0);
        chk("rst_async_d1", bus.out_data1, 32'h0);
        chk("rst_async_cnt", bus.stall_cnt, 16'h0);
        bus.stall = 2'b10;
        #1 chk("rst_ready_stalled", bus.in_ready, 1'b0);
        bus.stall = 2'b00;
        #1 chk("rst_ready_free", bus.in_ready, 1'b1);
        model_clear();
        @(negedge clk);
        reset = 1'b0;

        // Streaming: 1,2,3 appear after edges 2,3,4.
        do_reset();
        bus.in_valid = 1'b1; bus.in_data1 = 32'h1; cycle();
        bus.in_data1 = 32'h2; cycle();
        chk("stream_1", bus.out_data1, 32'h1); chk("stream_v1", bus.out_valid, 1'b1);
        bus.in_data1 = 32'h3; cycle();
        chk("stream_2", bus.out_data1, 32'h2);
        bus.in_valid = 1'b0; cycle();
        chk("stream_3", bus.out_data1, 32'h3); chk("stream_v3", bus.out_valid, 1'b1);

        // Bubble insertion behind a stage-0 stall.
        do_reset();
        bus.in_valid = 1'b1; bus.in_data1 = 32'h5; cycle();
        bus.stall = 2'b01; bus.in_data1 = 32'h6;
        #1 chk("bubble_ready", bus.in_ready, 1'b0);
        cycle();
        chk("bubble_valid", bus.out_valid, 1'b0); chk("bubble_d1", bus.out_data1, 32'h0);
        bus.stall = 2'b00; bus.in_valid = 1'b0; cycle();
        chk("bubble_after", bus.out_data1, 32'h5); chk("bubble_cnt", bus.stall_cnt, 16'd1);

        // Back-pressure from the output stage.
        do_reset();
        bus.in_valid = 1'b1; bus.in_data1 = 32'hA; cycle();
        bus.in_data1 = 32'hB; cycle();
        bus.stall = 2'b10; bus.in_data1 = 32'hC;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold", bus.out_data1, 32'hA);
        end
        bus.stall = 2'b00; bus.in_valid = 1'b0; cycle();
        chk("bp_next", bus.out_data1, 32'hB); chk("bp_cnt", bus.stall_cnt, 16'd3);

        // Flush overrides stall on the same stage.
        do_reset();
        bus.in_valid = 1'b1; bus.in_data1 = 32'h11; cycle();
        bus.in_data1 = 32'h22; cycle();
        bus.stall = 2'b11; bus.flush = 2'b10; cycle();
        chk("flush_valid", bus.out_valid, 1'b0); chk("flush_d1", bus.out_data1, 32'h0);
        bus.stall = 2'b00; bus.flush = 2'b00; bus.in_valid = 1'b0; cycle();
        chk("flush_s0_kept", bus.out_data1, 32'h22);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_data1 = $urandom; bus.in_data2 = $urandom; bus.in_func = 4'($urandom);
            bus.stall = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            bus.flush = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            cycle();
        end
        bus.stall = '0; bus.flush = '0; bus.in_valid = 1'b0;

        // Single-stage instance: one-cycle latency and counter saturation.
        do_reset();
        sif.in_valid = 1'b1; sif.in_data1 = 32'h77; sif.in_func = 4'h3;
        cycle();
        chk("s1_valid", sif.out_valid, 1'b1); chk("s1_d1", sif.out_data1, 32'h77);
        sif.stall = 1'b1; sif.in_data1 = 32'h88;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            chk("sat_cnt", sif.stall_cnt, (i > 15) ? 15 : i);
        end
        chk("sat_ready", sif.in_ready, 1'b0);
        chk("sat_hold_d1", sif.out_data1, 32'h77);
        sif.stall = 1'b0; cycle();
        chk("sat_final", sif.stall_cnt, 4'd15);
        chk("s1_resume", sif.out_data1, 32'h88);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
